vrf_write_merge_stage: RTL and testbench

- Sits directly downstream of lane stage 3's VRF write request FIFO, between that FIFO and the VRF write port.
- Holds one write entry and merges back-to-back partial-mask writes to the same vd/offset/instruction into a single VRF write.
- Seals the entry on a mismatch, full mask, last, flush or idle timeout, then issues it.
- Pulses a per-instruction done indication when a last-flagged write retires.

---
 rtl/vrf_write_merge_stage.sv | 202 ++++++++++++++++++++
 tb/tb_vrf_write_merge_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_write_merge_stage.sv
// Single-entry write merge buffer between the lane VRF write request FIFO and the VRF write port.
// Same-target partial writes are coalesced until a seal event, then issued from registered outputs.
module vrf_write_merge_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int MERGE_TIMEOUT = 4,
  localparam int MASK_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_vd,
  input  logic [2:0]            in_offset,
  input  logic [MASK_WIDTH-1:0] in_mask,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [2:0]            in_instructionIndex,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_vd,
  output logic [2:0]            out_offset,
  output logic [MASK_WIDTH-1:0] out_mask,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [2:0]            out_instructionIndex,
  output logic                  done_valid,
  output logic [2:0]            done_instructionIndex,
  output logic                  idle
);

  localparam int CNT_W = (MERGE_TIMEOUT < 1) ? 1 : $clog2(MERGE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(MERGE_TIMEOUT);
  localparam logic NO_MERGE = (MERGE_TIMEOUT == 0);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_OPEN   = 2'd1,
    ST_SEALED = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [4:0]            r_vd;
  logic [2:0]            r_offset;
  logic [MASK_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [2:0]            r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  r_done_valid;
  logic [2:0]            r_done_idx;
  logic                  w_in_ready;
  logic                  w_load;
  logic                  w_merge;
  logic                  w_match;
  logic                  w_out_valid;
  logic                  w_out_fire;
  logic                  w_load_seal;
  logic [MASK_WIDTH-1:0] w_merged_mask;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_d,
    input logic [DATA_WIDTH-1:0] new_d,
    input logic [MASK_WIDTH-1:0] m
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_d;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      res[8*i +: 8] = m[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
    end
    return res;
  endfunction

  assign w_match       = (in_vd == r_vd) && (in_offset == r_offset) && (in_instructionIndex == r_idx);
  assign w_out_valid   = (r_state == ST_SEALED);
  assign w_out_fire    = w_out_valid & out_ready;
  assign w_load_seal   = (&in_mask) | in_last | flush | NO_MERGE;
  assign w_merged_mask = r_mask | in_mask;
  assign w_cnt_inc     = r_cnt + CNT_W'(1);

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    w_merge     = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_EMPTY: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_load_seal ? ST_SEALED : ST_OPEN;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_OPEN: begin
        // Ready only for a matching request, so a mismatch is never consumed here
        w_in_ready = in_valid & w_match;
        if (in_valid & w_match) begin
          w_merge     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ((&w_merged_mask) | in_last | flush) ? ST_SEALED : ST_OPEN;
        end else if (in_valid | flush) begin
          w_state_nxt = ST_SEALED;
        end else if (r_cnt == TO_VAL) begin
          w_state_nxt = ST_SEALED;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = (w_cnt_inc == TO_VAL) ? ST_SEALED : ST_OPEN;
        end
      end
      ST_SEALED: begin
        w_in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_load      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = w_load_seal ? ST_SEALED : ST_OPEN;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else begin
          w_state_nxt = ST_SEALED;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and idle counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Held write entry: load replaces, merge overlays enabled bytes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vd     <= 5'd0;
      r_offset <= 3'd0;
      r_mask   <= '0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_idx    <= 3'd0;
    end else if (w_load) begin
      r_vd     <= in_vd;
      r_offset <= in_offset;
      r_mask   <= in_mask;
      r_data   <= in_data;
      r_last   <= in_last;
      r_idx    <= in_instructionIndex;
    end else if (w_merge) begin
      r_mask   <= w_merged_mask;
      r_data   <= merge_bytes(r_data, in_data, in_mask);
      r_last   <= r_last | in_last;
    end else begin
      r_mask   <= r_mask;
      r_data   <= r_data;
    end
  end

  // Per-instruction completion pulse, one cycle after a last write retires
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_done_valid <= 1'b0;
      r_done_idx   <= 3'd0;
    end else if (w_out_fire & r_last) begin
      r_done_valid <= 1'b1;
      r_done_idx   <= r_idx;
    end else begin
      r_done_valid <= 1'b0;
      r_done_idx   <= 3'd0;
    end
  end

  assign in_ready              = w_in_ready;
  assign out_valid             = w_out_valid;
  assign out_vd                = r_vd;
  assign out_offset            = r_offset;
  assign out_mask              = r_mask;
  assign out_data              = r_data;
  assign out_last              = r_last;
  assign out_instructionIndex  = r_idx;
  assign done_valid            = r_done_valid;
  assign done_instructionIndex = r_done_idx;
  assign idle                  = (r_state == ST_EMPTY);

endmodule

// File: tb/tb_vrf_write_merge_stage.sv
// Directed bench for vrf_write_merge_stage; a second instance with merging disabled
// shares the inputs and is observed only during the timeout step.
module tb_vrf_write_merge_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [4:0]  in_vd;
  logic [2:0]  in_offset;
  logic [3:0]  in_mask;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_idx;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, done_valid, idle;
  logic [4:0]  out_vd;
  logic [2:0]  out_offset, out_idx, done_idx;
  logic [3:0]  out_mask;
  logic [31:0] out_data;

  logic        z_in_ready, z_out_valid, z_out_last, z_done_valid, z_idle;
  logic [4:0]  z_out_vd;
  logic [2:0]  z_out_offset, z_out_idx, z_done_idx;
  logic [3:0]  z_out_mask;
  logic [31:0] z_out_data;

  int errors = 0;
  int checks = 0;

  vrf_write_merge_stage #(.DATA_WIDTH(32), .MERGE_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vd(in_vd), .in_offset(in_offset), .in_mask(in_mask), .in_data(in_data),
    .in_last(in_last), .in_instructionIndex(in_idx), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_vd(out_vd), .out_offset(out_offset),
    .out_mask(out_mask), .out_data(out_data), .out_last(out_last),
    .out_instructionIndex(out_idx), .done_valid(done_valid),
    .done_instructionIndex(done_idx), .idle(idle)
  );

  vrf_write_merge_stage #(.DATA_WIDTH(32), .MERGE_TIMEOUT(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_vd(in_vd), .in_offset(in_offset), .in_mask(in_mask), .in_data(in_data),
    .in_last(in_last), .in_instructionIndex(in_idx), .flush(flush),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_vd(z_out_vd), .out_offset(z_out_offset),
    .out_mask(z_out_mask), .out_data(z_out_data), .out_last(z_out_last),
    .out_instructionIndex(z_out_idx), .done_valid(z_done_valid),
    .done_instructionIndex(z_done_idx), .idle(z_idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] vd, input logic [2:0] off,
                       input logic [3:0] m, input logic [31:0] d, input logic l,
                       input logic [2:0] idx);
    in_valid  = v;
    in_vd     = vd;
    in_offset = off;
    in_mask   = m;
    in_data   = d;
    in_last   = l;
    in_idx    = idx;
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 5'd0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);

    // Reset values
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_mask", 64'(out_mask), 64'd0);
    chk("rst_out_vd", 64'(out_vd), 64'd0);
    repeat (2) cyc();
    reset_n = 1'b1;

    // Merge of two halves
    out_ready = 1'b1;
    drive(1'b1, 5'd3, 3'd2, 4'h3, 32'h0000AABB, 1'b0, 3'd1);
    chk("merge_rdy0", 64'(in_ready), 64'd1);
    cyc();
    chk("merge_open_valid", 64'(out_valid), 64'd0);
    chk("merge_open_idle", 64'(idle), 64'd0);
    drive(1'b1, 5'd3, 3'd2, 4'hC, 32'hCCDD0000, 1'b0, 3'd1);
    chk("merge_rdy1", 64'(in_ready), 64'd1);
    cyc();
    drive(1'b0, 5'd0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    chk("merge_valid", 64'(out_valid), 64'd1);
    chk("merge_mask", 64'(out_mask), 64'hF);
    chk("merge_data", 64'(out_data), 64'hCCDDAABB);
    chk("merge_vd", 64'(out_vd), 64'd3);
    chk("merge_off", 64'(out_offset), 64'd2);
    chk("merge_idx", 64'(out_idx), 64'd1);
    cyc();
    chk("merge_after_idle", 64'(idle), 64'd1);
    chk("merge_no_done", 64'(done_valid), 64'd0);

    // Mismatch seal, then the blocked request is taken on out_fire
    drive(1'b1, 5'd3, 3'd2, 4'h1, 32'h00000011, 1'b0, 3'd0);
    cyc();
    drive(1'b1, 5'd3, 3'd3, 4'h1, 32'h00000022, 1'b0, 3'd0);
    chk("mm_not_ready", 64'(in_ready), 64'd0);
    chk("mm_open_valid", 64'(out_valid), 64'd0);
    cyc();
    chk("mm_sealed_valid", 64'(out_valid), 64'd1);
    chk("mm_sealed_mask", 64'(out_mask), 64'h1);
    chk("mm_sealed_off", 64'(out_offset), 64'd2);
    chk("mm_sealed_byte", 64'(out_data[7:0]), 64'h11);
    chk("mm_ready_on_fire", 64'(in_ready), 64'd1);
    cyc();
    drive(1'b0, 5'd0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    chk("mm_reload_open", 64'(out_valid), 64'd0);
    chk("mm_reload_busy", 64'(idle), 64'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd1);
    chk("flush_off", 64'(out_offset), 64'd3);
    chk("flush_byte", 64'(out_data[7:0]), 64'h22);
    cyc();
    chk("flush_idle", 64'(idle), 64'd1);
    chk("z_idle_pre_to", 64'(z_idle), 64'd1);

    // Idle timeout: 5 cycles with merging, 1 cycle without
    drive(1'b1, 5'd1, 3'd0, 4'h2, 32'h0000EE00, 1'b0, 3'd2);
    cyc();
    drive(1'b0, 5'd0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    chk("z_to_valid1", 64'(z_out_valid), 64'd1);
    chk("z_to_mask", 64'(z_out_mask), 64'h2);
    chk("z_to_data", 64'(z_out_data), 64'h0000EE00);
    chk("z_to_vd", 64'(z_out_vd), 64'd1);
    chk("z_to_off", 64'(z_out_offset), 64'd0);
    chk("z_to_idx", 64'(z_out_idx), 64'd2);
    chk("z_to_last", 64'(z_out_last), 64'd0);
    chk("z_to_ready", 64'(z_in_ready), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("to_valid_c%0d", k), 64'(out_valid), (k == 5) ? 64'd1 : 64'd0);
      if (k == 2) begin
        chk("z_to_valid2", 64'(z_out_valid), 64'd0);
        chk("z_to_done", 64'(z_done_valid), 64'd0);
        chk("z_to_done_idx", 64'(z_done_idx), 64'd0);
      end else begin
        checks = checks;
      end
      if (k < 5) cyc();
      else checks = checks;
    end
    chk("to_mask", 64'(out_mask), 64'h2);
    cyc();
    chk("to_idle", 64'(idle), 64'd1);

    // Backpressure with last, then done pulse
    out_ready = 1'b0;
    drive(1'b1, 5'd7, 3'd1, 4'h1, 32'h00000055, 1'b1, 3'd5);
    cyc();
    drive(1'b1, 5'd0, 3'd0, 4'hF, 32'h00000099, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_valid_%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_vd_%0d", k), 64'(out_vd), 64'd7);
      chk($sformatf("bp_data_%0d", k), 64'(out_data), 64'h55);
      chk($sformatf("bp_mask_%0d", k), 64'(out_mask), 64'h1);
      chk($sformatf("bp_last_%0d", k), 64'(out_last), 64'd1);
      chk($sformatf("bp_idx_%0d", k), 64'(out_idx), 64'd5);
      chk($sformatf("bp_rdy_%0d", k), 64'(in_ready), 64'd0);
      chk($sformatf("bp_done_%0d", k), 64'(done_valid), 64'd0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 64'(in_ready), 64'd1);
    cyc();
    drive(1'b0, 5'd0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    chk("bp_done", 64'(done_valid), 64'd1);
    chk("bp_done_idx", 64'(done_idx), 64'd5);
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_data", 64'(out_data), 64'h99);
    cyc();
    chk("bp_done_clear", 64'(done_valid), 64'd0);
    chk("bp_idle", 64'(idle), 64'd1);

    // Streaming full-mask writes, one per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i), 3'(i), 4'hF, 32'hA0000000 + 32'(i), 1'b0, 3'(i));
      chk($sformatf("st_rdy_%0d", i), 64'(in_ready), 64'd1);
      if (i > 0) begin
        chk($sformatf("st_valid_%0d", i), 64'(out_valid), 64'd1);
        chk($sformatf("st_data_%0d", i), 64'(out_data), 64'hA0000000 + 64'(i - 1));
        chk($sformatf("st_vd_%0d", i), 64'(out_vd), 64'(i - 1));
      end else begin
        chk("st_valid_0", 64'(out_valid), 64'd0);
      end
      cyc();
    end
    drive(1'b0, 5'd0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    chk("st_valid_tail", 64'(out_valid), 64'd1);
    chk("st_data_tail", 64'(out_data), 64'hA0000007);
    cyc();
    chk("st_idle", 64'(idle), 64'd1);

    // Zero mask is still issued
    drive(1'b1, 5'd4, 3'd0, 4'h0, 32'h12345678, 1'b0, 3'd3);
    cyc();
    drive(1'b0, 5'd0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("zm_valid", 64'(out_valid), 64'd1);
    chk("zm_mask", 64'(out_mask), 64'h0);
    chk("zm_vd", 64'(out_vd), 64'd4);
    cyc();

    // Async reset while OPEN
    drive(1'b1, 5'd2, 3'd0, 4'h1, 32'h1, 1'b0, 3'd0);
    cyc();
    drive(1'b0, 5'd0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    cyc();
    chk("ar_open_cnt", 64'(dut.r_cnt), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_open_valid", 64'(out_valid), 64'd0);
    chk("ar_open_idle", 64'(idle), 64'd1);
    chk("ar_open_cnt0", 64'(dut.r_cnt), 64'd0);
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ar_open_quiet_%0d", k), 64'(out_valid), 64'd0);
      cyc();
    end

    // Async reset while SEALED with a done pulse pending
    out_ready = 1'b0;
    drive(1'b1, 5'd6, 3'd0, 4'hF, 32'h77, 1'b1, 3'd6);
    cyc();
    out_ready = 1'b1;
    drive(1'b1, 5'd5, 3'd0, 4'hF, 32'h88, 1'b0, 3'd0);
    cyc();
    out_ready = 1'b0;
    drive(1'b0, 5'd0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    chk("ar_seal_pre_done", 64'(done_valid), 64'd1);
    chk("ar_seal_pre_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("ar_seal_done", 64'(done_valid), 64'd0);
    chk("ar_seal_valid", 64'(out_valid), 64'd0);
    chk("ar_seal_idle", 64'(idle), 64'd1);
    cyc();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ar_seal_quiet_%0d", k), 64'(out_valid), 64'd0);
      chk($sformatf("ar_seal_nodone_%0d", k), 64'(done_valid), 64'd0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
